// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: one registered one-hot grant shared by N requesters,
// released on last beat, dropped request, or hold watchdog expiry.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no owner, gnt is zero, arbitrating every cycle from ptr
// ST_OWN  | gnt_id owns the resource, hold_cnt counts granted cycles
module rr_burst_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   last,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
    localparam logic [IDW-1:0] LAST_IDX  = IDW'(N - 1);

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           timeout_q, timeout_d;

    logic           own_req;
    logic           own_last;
    logic           wd_hit;
    logic           rel;
    logic           arbitrate;
    logic [IDW-1:0] arb_ptr;
    logic [IDW:0]   win;

    // Returns {found, index} of the first set request at or after p, wrapping at N.
    function automatic logic [IDW:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
        logic [IDW:0] res;
        int           j;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(p) + i;
            if (j >= N) j = j - N;
            if (r[j]) res = {1'b1, IDW'(j)};
        end
        return res;
    endfunction

    assign own_req  = req[gnt_id_q];
    assign own_last = last[gnt_id_q];
    assign wd_hit   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        rel        = 1'b0;
        arbitrate  = 1'b0;
        arb_ptr    = ptr_q;
        win        = '0;

        case (state_q)
            ST_IDLE: begin
                hold_cnt_d = '0;
                arbitrate  = 1'b1;
            end
            ST_OWN: begin
                rel = ~own_req | own_last | wd_hit;
                if (!rel) begin
                    hold_cnt_d = (MAX_HOLD != 0) ? hold_cnt_q + HCW'(1) : '0;
                end else begin
                    // Only a pure watchdog expiry is flagged; last or a dropped req wins.
                    timeout_d = wd_hit & own_req & ~own_last;
                    arb_ptr   = (gnt_id_q == LAST_IDX) ? '0 : gnt_id_q + IDW'(1);
                    ptr_d     = arb_ptr;
                    arbitrate = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        if (arbitrate) begin
            win        = pick(req, arb_ptr);
            hold_cnt_d = '0;
            if (win[IDW]) begin
                state_d  = ST_OWN;
                gnt_d    = N'(1) << win[IDW-1:0];
                gnt_id_d = win[IDW-1:0];
            end else begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = |gnt_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: an N=4/MAX_HOLD=16 and an N=3/MAX_HOLD=3 instance share
// stimulus and are compared each cycle against an owner/pointer reference model.
module tb_rr_burst_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, last;

    logic [3:0] gnt4;
    logic [1:0] id4;
    logic       busy4, to4;
    logic [2:0] gnt3;
    logic [1:0] id3;
    logic       busy3, to3;

    int n_checks = 0;
    int n_fail   = 0;

    int m_n  [2] = '{4, 3};
    int m_mh [2] = '{16, 3};
    int m_owner[2];
    int m_ptr  [2];
    int m_hold [2];
    int m_id   [2];
    int m_to   [2];

    always #5 clk = ~clk;

    rr_burst_arbiter #(.N(4), .MAX_HOLD(16), .IDW(2)) u_arb4 (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last),
        .gnt(gnt4), .gnt_id(id4), .busy(busy4), .timeout(to4)
    );

    rr_burst_arbiter #(.N(3), .MAX_HOLD(3), .IDW(2)) u_arb3 (
        .clk(clk), .rst_n(rst_n), .req(req[2:0]), .last(last[2:0]),
        .gnt(gnt3), .gnt_id(id3), .busy(busy3), .timeout(to3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_req(input logic [3:0] r, input int n, input int p);
        for (int i = 0; i < n; i++)
            if (r[(p + i) % n]) return (p + i) % n;
        return -1;
    endfunction

    function automatic int exp_gnt(input int k);
        return (m_owner[k] < 0) ? 0 : (1 << m_owner[k]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_ptr[k] = 0; m_hold[k] = 0; m_id[k] = 0; m_to[k] = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] l);
        int  o, w;
        bit  wd, release_now;
        for (int k = 0; k < 2; k++) begin
            m_to[k] = 0;
            release_now = 1;
            if (m_owner[k] >= 0) begin
                o  = m_owner[k];
                wd = (m_mh[k] != 0) && (m_hold[k] == m_mh[k] - 1);
                release_now = !r[o] || l[o] || wd;
                if (!release_now) begin
                    m_hold[k]++;
                end else begin
                    m_to[k]  = (wd && r[o] && !l[o]) ? 1 : 0;
                    m_ptr[k] = (o + 1) % m_n[k];
                end
            end
            if (release_now) begin
                w = first_req(r, m_n[k], m_ptr[k]);
                m_hold[k]  = 0;
                m_owner[k] = w;
                if (w >= 0) m_id[k] = w;
            end
        end
    endtask

    task automatic compare_all();
        chk("gnt4",     32'(gnt4),  32'(exp_gnt(0)));
        chk("gnt_id4",  32'(id4),   32'(m_id[0]));
        chk("busy4",    32'(busy4), 32'(m_owner[0] >= 0));
        chk("timeout4", 32'(to4),   32'(m_to[0]));
        chk("gnt3",     32'(gnt3),  32'(exp_gnt(1)));
        chk("gnt_id3",  32'(id3),   32'(m_id[1]));
        chk("busy3",    32'(busy3), 32'(m_owner[1] >= 0));
        chk("timeout3", 32'(to3),   32'(m_to[1]));
    endtask

    // Called at a negedge: drive, clock, advance model, check at the next negedge.
    task automatic step(input logic [3:0] r, input logic [3:0] l);
        req  = r;
        last = l;
        @(posedge clk);
        model_step(r, l);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int run;
        bit seen;
        logic [3:0] r, l;

        req = '0; last = '0; rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // single short burst from requester 2, then ptr must sit at 3
        step(4'b0100, 4'b0100);
        chk("t1_gnt", 32'(gnt4), 32'h4);
        chk("t1_id",  32'(id4),  32'd2);
        step(4'b0000, 4'b0000);
        chk("t1_idle", 32'(gnt4), 32'h0);
        step(4'b1111, 4'b0000);
        chk("t1_ptr3", 32'(gnt4), 32'h8);

        // all requesting, each owner ends on its second beat
        for (int i = 0; i < 12; i++) begin
            l = (m_owner[0] >= 0 && m_hold[0] == 1) ? 4'(1 << m_owner[0]) : 4'b0000;
            step(4'b1111, l);
        end

        // sole requester, watchdog expiry
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        run = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0001, 4'b0000);
            if (to4 && !seen) begin
                chk("t3_hold_len", 32'(run), 32'd16);
                chk("t3_regrant",  32'(gnt4), 32'h1);
                seen = 1;
            end else if (!seen && gnt4[0]) begin
                run++;
            end
        end
        if (!seen) chk("t3_timeout_seen", 32'(to4), 32'd1);

        // owner 1 drops request while 3 waits
        step(4'b0000, 4'b0000);
        step(4'b0010, 4'b0000);
        chk("t4_own1", 32'(gnt4), 32'h2);
        step(4'b1010, 4'b0000);
        step(4'b1000, 4'b0000);
        chk("t4_gnt3", 32'(gnt4), 32'h8);
        chk("t4_noto", 32'(to4),  32'd0);

        // N=3 pointer wrap from owner 2 back to 0
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        step(4'b0100, 4'b0000);
        chk("t5_own2", 32'(gnt3), 32'h4);
        step(4'b0101, 4'b0100);
        chk("t5_wrap", 32'(gnt3), 32'h1);

        // asynchronous reset in the middle of a burst
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        step(4'b0010, 4'b0000);
        chk("t6_own1", 32'(gnt4), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_gnt",  32'(gnt4),  32'h0);
        chk("t6_rst_busy", 32'(busy4), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        step(4'b1111, 4'b0000);
        chk("t6_ptr0", 32'(gnt4), 32'h1);

        // randomized traffic with periodic long-hold phases to exercise the watchdog
        for (int i = 0; i < 3000; i++) begin
            if ((i % 250) < 40) begin
                r = ((i / 250) % 2 == 0) ? 4'b1111 : 4'(1 << $urandom_range(0, 3));
                l = 4'b0000;
            end else begin
                r = 4'($urandom);
                l = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            end
            step(r, l);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
